// File: rtl/nor_pkg.sv
// Shared constants and types for the 16-bit zero-detect leaf.
package nor_pkg;
   localparam int NOR_WIDTH   = 16;
   localparam int NOR_GROUP   = 4;
   localparam int GATE_DLY_PS = 50;

   typedef logic [NOR_WIDTH-1:0] nor16_word_t;
endpackage

// File: rtl/nor_16_if.sv
// Operand/result bundle for nor_16: master drives the operand, slave returns the results.
interface nor_16_if;
   import nor_pkg::*;

   nor16_word_t in;
   logic        in_valid;
   logic        out;
   logic        out_q;
   logic        out_valid;

   modport master (output in, output in_valid, input out, input out_q, input out_valid);
   modport slave  (input in, input in_valid, output out, output out_q, output out_valid);
endinterface

// File: rtl/nor_4.sv
// 4-input NOR as a single gate primitive; per-gate delay when NOR_16_GATE_DELAY_EN is defined.
module nor_4
`ifdef NOR_16_GATE_DELAY_EN
   #(parameter int unsigned GATE_DLY = nor_pkg::GATE_DLY_PS)
`endif
(
   input  wire [3:0] i_a,
   output wire       o_y
);
`ifdef NOR_16_GATE_DELAY_EN
   nor #(GATE_DLY) u_nor (o_y, i_a[0], i_a[1], i_a[2], i_a[3]);
`else
   nor u_nor (o_y, i_a[0], i_a[1], i_a[2], i_a[3]);
`endif
endmodule

// File: rtl/nor_16.sv
// 16-bit zero detect: nibble NORs feeding an AND4, plus a registered copy with valid.
// Optional per-gate delays via NOR_16_GATE_DELAY_EN.
module nor_16
   import nor_pkg::*;
`ifdef NOR_16_GATE_DELAY_EN
   #(parameter int unsigned GATE_DLY = GATE_DLY_PS)
`endif
(
   input  logic     clk,
   input  logic     reset,
   nor_16_if.slave  bus
);
   localparam int NUM_NIB = NOR_WIDTH / NOR_GROUP;

   wire  [NOR_WIDTH-1:0] w_in;
   wire  [NUM_NIB-1:0]   w_nib;
   wire                  w_zero;
   logic                 r_out_q;
   logic                 r_out_valid;

   assign w_in = bus.in;

   for (genvar g = 0; g < NUM_NIB; g++) begin : g_nib
`ifdef NOR_16_GATE_DELAY_EN
      nor_4 #(.GATE_DLY(GATE_DLY)) u_nor_4 (
`else
      nor_4 u_nor_4 (
`endif
         .i_a (w_in[g*NOR_GROUP +: NOR_GROUP]),
         .o_y (w_nib[g])
      );
   end

`ifdef NOR_16_GATE_DELAY_EN
   and #(GATE_DLY) u_and4 (w_zero, w_nib[0], w_nib[1], w_nib[2], w_nib[3]);
`else
   and u_and4 (w_zero, w_nib[0], w_nib[1], w_nib[2], w_nib[3]);
`endif

   // out_q only updates on qualified cycles; valid tracks in_valid every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_q     <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= bus.in_valid;
         if (bus.in_valid) r_out_q <= w_zero;
      end
   end

   assign bus.out       = w_zero;
   assign bus.out_q     = r_out_q;
   assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_nor_16.sv
// Randomized scoreboard bench for nor_16: expected registered results queued at stimulus time.
`timescale 1ps/1ps
module tb_nor_16;
   import nor_pkg::*;

   typedef struct packed {
      logic v;
      logic q;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;
   logic last_q = 1'b0;
   exp_t sb[$];

   nor_16_if bus ();

   nor_16 u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #500 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: zero detect is simply "the word equals zero".
   function automatic logic ref_zero(input nor16_word_t d);
      return (d == 16'h0000) ? 1'b1 : 1'b0;
   endfunction

   task automatic cycle(input nor16_word_t d, input logic v);
      @(negedge clk);
      bus.in = d;
      bus.in_valid = v;
      if (v) last_q = ref_zero(d);
      sb.push_back('{v: v, q: last_q});
      #101;
      check("comb_out", bus.out, ref_zero(d));
   endtask

   // Asserted after the comb check of the current cycle; clears state before the next edge.
   task automatic mid_reset();
      logic out_before;
      out_before = bus.out;
      #100;
      reset = 1'b1;
      #1;
      check("rst_out_q", bus.out_q, 1'b0);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_unchanged", bus.out, out_before);
      #100;
      reset = 1'b0;
      if (!sb[$].v) begin
         sb[$].q = 1'b0;
         last_q = 1'b0;
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("out_valid", bus.out_valid, e.v);
         check("out_q", bus.out_q, e.q);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      nor16_word_t d;
      bus.in = 16'h0000;
      bus.in_valid = 1'b0;
      #200;
      check("reset_out_q", bus.out_q, 1'b0);
      check("reset_out_valid", bus.out_valid, 1'b0);
      check("reset_comb_out", bus.out, 1'b1);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      cycle(16'h0000, 1'b1);
      cycle(16'h0001, 1'b1);
      cycle(16'h8000, 1'b1);
      cycle(16'h5555, 1'b1);
      cycle(16'h7713, 1'b1);
      cycle(16'h0000, 1'b1);

      for (int k = 0; k < 16; k++) begin
         d = 16'h0001 << k;
         cycle(d, 1'b1);
      end

      for (int i = 0; i < 1000; i++) begin
         case ($urandom_range(0, 3))
            0:       d = 16'h0000;
            1:       d = 16'h0001 << $urandom_range(0, 15);
            default: d = 16'($urandom);
         endcase
         cycle(d, 1'($urandom_range(0, 1)));
      end

      cycle(16'h0000, 1'b1);
      cycle(16'h0000, 1'b1);
      mid_reset();
      cycle(16'h0000, 1'b1);
      cycle(16'hFFFF, 1'b0);
      mid_reset();

      cycle(16'h0000, 1'b1);
      for (int i = 0; i < 6; i++) cycle((i % 2 == 0) ? 16'hFFFF : 16'h0000, 1'b0);
      cycle(16'h0100, 1'b1);
      for (int i = 0; i < 4; i++) cycle((i % 2 == 0) ? 16'h0000 : 16'hFFFF, 1'b0);

      repeat (2) @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
